// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM state encoding, rt-usage helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    // True when the instruction reads rt as a source operand. lw writes rt, so it
    // is excluded; unrecognised opcodes are assumed to read rs only.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating 32-bit event counter, one increment per cycle with inc high.
// Latency: count visible the cycle after the event.
// Backpressure: none; sticks at all-ones instead of wrapping.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    // Count events, holding at the maximum value once reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS 5-stage hazard controller: load-use stall, MEM-resolved branch flush, dmem-wait freeze (HAZARD_PERF_EN adds perf counters).
// Latency: control outputs are combinational from state and inputs; state/timeout update on the next edge.
// Backpressure: a pending dmem access freezes every stage; MAX_WAIT consecutive wait cycles latch a sticky timeout and halt.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        pipe_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic        pc_src,
    output logic        mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_br,
    output logic [31:0] perf_wait
`endif
);

    hz_state_t          state;
    hz_state_t          nxt_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               lu;
    logic               run_rules;
    logic               cnt_load;
    logic               cnt_inc;
    logic               set_timeout;

    // Load-use: the load in EX writes a register the ID instruction reads. $0 never hazards.
    assign lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (op_uses_rt(id_op) && (ex_rt == id_rt)));

    // Next-state and enable/flush decode; branch outranks load-use whenever the pipe can move.
    always_comb begin
        nxt_state   = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pipe_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pc_src      = 1'b0;
        run_rules   = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        set_timeout = 1'b0;
        case (state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_write = 1'b0;
                    cnt_load   = 1'b1;
                    nxt_state  = MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_write = 1'b0;
                    if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                        nxt_state   = HALT;
                        set_timeout = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    // Access completes: resume and resolve hazards in this same cycle.
                    nxt_state = RUN;
                    run_rules = 1'b1;
                end
            end
            default: begin
                // HALT (and any illegal encoding): everything frozen until reset.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_write = 1'b0;
            end
        endcase
        if (run_rules) begin
            if (mem_branch_taken) begin
                pc_src      = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // FSM state, saturating wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= nxt_state;
            if (cnt_load) begin
                wait_cnt <= CNT_W'(1);
            end else if (cnt_inc && (wait_cnt != {CNT_W{1'b1}})) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic perf_inc_lu;
    logic perf_inc_br;
    logic perf_inc_wait;

    assign perf_inc_lu   = run_rules && !mem_branch_taken && lu;
    assign perf_inc_br   = run_rules && mem_branch_taken;
    assign perf_inc_wait = cnt_load || ((state == MEM_WAIT) && !dmem_ready);

    hazard_perf_cnt u_cnt_lu (
        .clk (clk),
        .rst (rst),
        .inc (perf_inc_lu),
        .cnt (perf_lu)
    );

    hazard_perf_cnt u_cnt_br (
        .clk (clk),
        .rst (rst),
        .inc (perf_inc_br),
        .cnt (perf_br)
    );

    hazard_perf_cnt u_cnt_wait (
        .clk (clk),
        .rst (rst),
        .inc (perf_inc_wait),
        .cnt (perf_wait)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: scripted cycles with hand-derived expected control vectors.
// Latency: each cycle's expectation is queued at drive time and popped on the following negedge.
// Backpressure: not applicable.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        mem_branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        pipe_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_flush;
    logic        pc_src;
    logic        mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu;
    logic [31:0] perf_br;
    logic [31:0] perf_wait;
`endif

    // {pc_write, ifid_write, pipe_write, ifid_flush, idex_bubble, exmem_flush, pc_src, mem_timeout}
    localparam logic [7:0] V_NORM = 8'b1110_0000;
    localparam logic [7:0] V_LU   = 8'b0010_1000;
    localparam logic [7:0] V_BR   = 8'b1111_1110;
    localparam logic [7:0] V_FRZ  = 8'b0000_0000;
    localparam logic [7:0] V_HALT = 8'b0000_0001;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    hazard_ctrl #(
        .MAX_WAIT (4),
        .CNT_W    (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_op            (id_op),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .ex_memread       (ex_memread),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .pipe_write       (pipe_write),
        .ifid_flush       (ifid_flush),
        .idex_bubble      (idex_bubble),
        .exmem_flush      (exmem_flush),
        .pc_src           (pc_src),
        .mem_timeout      (mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu          (perf_lu),
        .perf_br          (perf_br),
        .perf_wait        (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge, queue its expected
    // control vector, then compare against the DUT on the falling edge.
    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] ert, input logic br,
                        input logic req, input logic rdy, input logic [7:0] exp);
        logic [7:0] obs;
        logic [7:0] want;
        @(posedge clk);
        #1;
        rst              = r;
        id_op            = op;
        id_rs            = rs;
        id_rt            = rt;
        ex_memread       = mr;
        ex_rt            = ert;
        mem_branch_taken = br;
        dmem_req         = req;
        dmem_ready       = rdy;
        sb_q.push_back(exp);
        @(negedge clk);
        obs  = {pc_write, ifid_write, pipe_write, ifid_flush,
                idex_bubble, exmem_flush, pc_src, mem_timeout};
        want = sb_q.pop_front();
        chk(tag, {24'd0, obs}, {24'd0, want});
    endtask

    initial begin
        rst = 1'b1; id_op = OP_RTYPE; id_rs = 5'd0; id_rt = 5'd0;
        ex_memread = 1'b0; ex_rt = 5'd0; mem_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //    tag          rst op        rs  rt  mr ert br req rdy exp
        step("reset_idle",  0, OP_RTYPE, 1,  2,  0, 0,  0, 0,  0,  V_NORM);
        step("lu_rs",       0, OP_RTYPE, 5,  6,  1, 5,  0, 0,  0,  V_LU);
        step("lu_after",    0, OP_RTYPE, 5,  6,  0, 5,  0, 0,  0,  V_NORM);
        step("lu_r0",       0, OP_RTYPE, 0,  3,  1, 0,  0, 0,  0,  V_NORM);
        step("lw_rt",       0, OP_LW,    3,  7,  1, 7,  0, 0,  0,  V_NORM);
        step("sw_rt",       0, OP_SW,    1,  7,  1, 7,  0, 0,  0,  V_LU);
        step("beq_rt",      0, OP_BEQ,   1,  7,  1, 7,  0, 0,  0,  V_LU);
        step("r_rt",        0, OP_RTYPE, 1,  7,  1, 7,  0, 0,  0,  V_LU);
        step("unk_rt",      0, OP_ADDI,  1,  7,  1, 7,  0, 0,  0,  V_NORM);
        step("unk_rs",      0, OP_ADDI,  7,  2,  1, 7,  0, 0,  0,  V_LU);
        step("br_lu",       0, OP_RTYPE, 5,  6,  1, 5,  1, 0,  0,  V_BR);
        step("br_only",     0, OP_RTYPE, 1,  2,  0, 0,  1, 0,  0,  V_BR);

        // Three frozen cycles, then release; a branch during the wait is ignored.
        step("wait_run",    0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("wait_1",      0, OP_RTYPE, 1,  2,  0, 0,  1, 1,  0,  V_FRZ);
        step("wait_2",      0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("wait_done",   0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  1,  V_NORM);
        step("wait_after",  0, OP_RTYPE, 1,  2,  0, 0,  0, 0,  0,  V_NORM);

        // Release cycle resolves a load-use hazard immediately.
        step("wlu_run",     0, OP_RTYPE, 9,  2,  1, 9,  0, 1,  0,  V_FRZ);
        step("wlu_done",    0, OP_RTYPE, 9,  2,  1, 9,  0, 1,  1,  V_LU);
        step("wlu_after",   0, OP_RTYPE, 9,  2,  0, 9,  0, 0,  0,  V_NORM);

        // Timeout with MAX_WAIT=4: one RUN stall, four MEM_WAIT cycles, then HALT.
        step("to_run",      0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("to_w1",       0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("to_w2",       0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("to_w3",       0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("to_w4",       0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("halt_1",      0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_HALT);
        step("halt_rdy",    0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  1,  V_HALT);
        step("halt_br",     0, OP_RTYPE, 5,  2,  1, 5,  1, 0,  0,  V_HALT);
        step("halt_rst",    1, OP_RTYPE, 1,  2,  0, 0,  0, 0,  0,  V_HALT);
        step("post_rst",    0, OP_RTYPE, 1,  2,  0, 0,  0, 0,  0,  V_NORM);

        // Reset landing on the second wait cycle.
        step("mw_run",      0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("mw_w1",       0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("mw_rst",      1, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("mw_post",     0, OP_RTYPE, 1,  2,  0, 0,  0, 0,  0,  V_NORM);
`ifdef HAZARD_PERF_EN
        chk("perf_lu_rst",   perf_lu,   32'd0);
        chk("perf_br_rst",   perf_br,   32'd0);
        chk("perf_wait_rst", perf_wait, 32'd0);
`endif
        step("pf_lu",       0, OP_RTYPE, 4,  2,  1, 4,  0, 0,  0,  V_LU);
        step("pf_br",       0, OP_RTYPE, 1,  2,  0, 0,  1, 0,  0,  V_BR);
        step("pf_wait",     0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  0,  V_FRZ);
        step("pf_done",     0, OP_RTYPE, 1,  2,  0, 0,  0, 1,  1,  V_NORM);
        step("pf_idle",     0, OP_RTYPE, 1,  2,  0, 0,  0, 0,  0,  V_NORM);
`ifdef HAZARD_PERF_EN
        chk("perf_lu",   perf_lu,   32'd1);
        chk("perf_br",   perf_br,   32'd1);
        chk("perf_wait", perf_wait, 32'd1);
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 32-bit MIPS pipeline (IF/ID/EX/MEM/WB).
- Decides each cycle which pipeline registers advance, stall or flush:
  - load-use stalls, using the ID-stage opcode and the EX-stage MemRead control bit;
  - taken-branch flushes, with the branch resolved in MEM;
  - whole-pipeline freezes while a multi-cycle data-memory access is outstanding.
- Sits beside the main control decoder; drives the write-enables and flush inputs of the PC and every pipeline register.

Parameters:
- MAX_WAIT, 16, maximum consecutive MEM_WAIT cycles before a timeout is declared (range 1..255).
- CNT_W, 8, width of the wait-cycle counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_op  in  6  opcode of the instruction in IF/ID.
- id_rs  in  5  rs field in IF/ID.
- id_rt  in  5  rt field in IF/ID.
- ex_memread  in  1  MemRead bit of ID/EX.M.
- ex_rt  in  5  rt field held in ID/EX.
- mem_branch_taken  in  1  Branch bit AND zero flag, from EX/MEM.
- dmem_req  in  1  EX/MEM instruction is accessing data memory (MemRead or MemWrite).
- dmem_ready  in  1  data memory has completed the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- pipe_write  out  1  shared load enable for ID/EX, EX/MEM and MEM/WB.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_bubble  out  1  zero the WB/M/EX control fields of ID/EX on the next edge.
- exmem_flush  out  1  zero the control fields of EX/MEM on the next edge.
- pc_src  out  1  select the branch target for the PC.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset enters RUN and clears wait_cnt and mem_timeout.
- Outputs are combinational from state and inputs.
- With no event, outputs are: pc_write=1, ifid_write=1, pipe_write=1, all flushes=0, pc_src=0.

- Load-use condition (lu):
  - Definition: ex_memread=1 AND ex_rt!=0 AND (ex_rt==id_rs OR (ex_rt==id_rt AND id_op uses rt)).
  - rt-users: R-type, sw, beq. lw does not count as an rt-user.
  - Unknown opcodes are treated as using rs only.

- RUN, priority highest first:
  1. dmem_req=1 AND dmem_ready=0:
     - pc_write=0, ifid_write=0, pipe_write=0, no flush;
     - next state MEM_WAIT; wait_cnt<=1.
  2. mem_branch_taken=1:
     - pc_src=1, ifid_flush=1, idex_bubble=1, exmem_flush=1;
     - all write enables stay at 1 (3-instruction flush);
     - lu is ignored in this cycle.
  3. lu=1:
     - pc_write=0, ifid_write=0, idex_bubble=1, pipe_write=1;
     - exactly one bubble is inserted; the condition clears itself on the next cycle.

- MEM_WAIT:
  - dmem_ready=0: all enables=0 and wait_cnt increments. If wait_cnt==MAX_WAIT, go to HALT and set mem_timeout.
  - dmem_ready=1: go to RUN. In the same cycle, apply the RUN rules 2 and 3 as though in RUN, so the pipeline advances with no extra cycle.
  - mem_branch_taken is ignored while waiting. beq never issues dmem_req.

- HALT: all enables=0 and all flushes=0. mem_timeout=1 until rst.
- Reset asserted mid-wait: next cycle is RUN with all counters cleared. A dmem_ready pulse in the reset cycle is ignored.
- wait_cnt saturates and never wraps.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - adds three 32-bit counters: lu_stalls, br_flushes, wait_cycles;
  - counters are cleared by rst and saturate at 0xFFFFFFFF;
  - each increments once per cycle in which its corresponding RUN/MEM_WAIT rule fires;
  - all three are exposed as output ports perf_lu, perf_br, perf_wait.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100;
  - the state enum {RUN, MEM_WAIT, HALT}.
- The main control decoder imports the same constants.
- One natural sub-module: hazard_perf_cnt, a saturating 32-bit counter instantiated three times under HAZARD_PERF_EN.

Test Plan:
- lw rt=5, then add with rs=5, so ex_memread=1, ex_rt=5, id_rs=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; the next cycle is normal.
- ex_memread=1, ex_rt=0, id_rs=0 -> no stall. Separately, ex_rt=7, id_op=lw, id_rt=7 -> no stall.
- mem_branch_taken=1 together with lu=1 -> pc_src=1 and all three flushes=1; no stall.
- dmem_req=1, dmem_ready held low for 3 cycles, then high -> 3 frozen cycles, then RUN with all enables=1.
- MAX_WAIT=4, dmem_ready stuck low -> HALT after 4 wait cycles; mem_timeout=1 stays set; rst returns to RUN with mem_timeout=0.
- rst asserted on the 2nd wait cycle -> RUN next cycle; with HAZARD_PERF_EN defined, perf_wait=0.
